// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg : shared opcode/state encodings and defaults for alu_seq_unit      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int c_default_width = 32;
    localparam int c_default_opw   = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_MUL = 4'd1,
        OP_SUB = 4'd2,
        OP_SHL = 4'd3,
        OP_SHR = 4'd4,
        OP_SAR = 4'd5,
        OP_AND = 4'd6,
        OP_OR  = 4'd7,
        OP_NOT = 4'd8,
        OP_XOR = 4'd9,
        OP_DIV = 4'd10
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_iter_muldiv : iterative unsigned shift-add multiply / restoring divide |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] c_last = 6'(WIDTH - 1);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_div;
    logic             r_active;
    logic             r_done;
    logic [5:0]       r_cnt;

    logic [WIDTH-1:0] w_hi_in;
    logic [WIDTH-1:0] w_lo_in;
    logic [WIDTH-1:0] w_b_in;
    logic             w_div_in;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Iteration 0 runs on the start edge itself, straight from the operand inputs.
    always_comb begin
        w_hi_in  = start ? '0 : r_hi;
        w_lo_in  = start ? a : r_lo;
        w_b_in   = start ? b : r_b;
        w_div_in = start ? is_div : r_div;
        w_sum    = {1'b0, w_hi_in} + (w_lo_in[0] ? {1'b0, w_b_in} : '0);
        w_shift  = {w_hi_in, w_lo_in[WIDTH-1]};
        w_hi_nxt = w_sum[WIDTH:1];
        w_lo_nxt = {w_sum[0], w_lo_in[WIDTH-1:1]};
        if (w_div_in) begin
            if (w_shift >= {1'b0, w_b_in}) begin
                w_hi_nxt = w_shift[WIDTH-1:0] - w_b_in;
                w_lo_nxt = {w_lo_in[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {w_lo_in[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_div    <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= 6'd0;
        end else if (start) begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_b      <= b;
            r_div    <= is_div;
            r_active <= 1'b1;
            r_done   <= 1'b0;
            r_cnt    <= 6'd1;
        end else if (r_active) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == c_last) begin
                r_cnt    <= 6'd0;
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 6'd1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq_unit : handshaked multi-cycle 32-bit ALU responder                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int OPW   = c_default_opw
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OPW-1:0]   req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             busy
);

    state_e           r_state;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_s;
    logic             w_carry;
    logic             w_ovf;
    logic             w_iter;
    logic             w_is_div;
    logic             w_start;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;

    assign w_sum    = {1'b0, req_a} + {1'b0, req_b};
    assign w_diff   = {1'b0, req_a} - {1'b0, req_b};
    assign w_is_div = (req_op == OP_DIV);
    assign w_start  = (r_state == IDLE) && req_valid && w_iter;

    // Single-cycle results; w_iter flags the ops handed to the iterative engine.
    always_comb begin
        w_s     = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_iter  = 1'b0;
        case (req_op)
            OP_ADD: begin
                w_s     = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (w_sum[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_MUL: w_iter = 1'b1;
            OP_SUB: begin
                w_s     = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (w_diff[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_SHL: begin
                w_s     = {req_a[WIDTH-2:0], 1'b0};
                w_carry = req_a[WIDTH-1];
            end
            OP_SHR: begin
                w_s     = {1'b0, req_a[WIDTH-1:1]};
                w_carry = req_a[0];
            end
            OP_SAR: begin
                w_s     = {req_a[WIDTH-1], req_a[WIDTH-1:1]};
                w_carry = req_a[0];
            end
            OP_AND: w_s = req_a & req_b;
            OP_OR:  w_s = req_a | req_b;
            OP_NOT: w_s = ~req_a;
            OP_XOR: w_s = req_a ^ req_b;
            OP_DIV: begin
                if (req_b == '0) begin
                    w_s   = '1;
                    w_ovf = 1'b1;
                end else begin
                    w_iter = 1'b1;
                end
            end
            default: w_ovf = 1'b1;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .is_div (w_is_div),
        .a      (req_a),
        .b      (req_b),
        .done   (w_md_done),
        .hi     (w_md_hi),
        .lo     (w_md_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            busy         <= 1'b0;
            rsp_s        <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (w_iter) begin
                            r_state <= w_is_div ? DIV : MUL;
                        end else begin
                            r_state      <= DONE;
                            rsp_valid    <= 1'b1;
                            rsp_s        <= w_s;
                            rsp_carry    <= w_carry;
                            rsp_overflow <= w_ovf;
                            rsp_zero     <= (w_s == '0);
                        end
                    end
                end
                MUL, DIV: begin
                    if (w_md_done) begin
                        r_state      <= DONE;
                        rsp_valid    <= 1'b1;
                        rsp_s        <= w_md_lo;
                        rsp_carry    <= 1'b0;
                        rsp_overflow <= (r_state == MUL) && (w_md_hi != '0);
                        rsp_zero     <= (w_md_lo == '0);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state   <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_seq_unit : randomized self-checking bench for alu_seq_unit          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_s;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    always #5 clk = ~clk;

    alu_seq_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_s        (rsp_s),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .busy         (busy)
    );

    // Reference: plain wide/signed arithmetic on the operation definitions.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        res_t        e;
        logic [63:0] w;
        longint      sa;
        longint      sb;
        longint      sr;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: begin
                w   = {32'b0, a} + {32'b0, b};
                e.s = w[31:0];
                e.c = w[32];
                sr  = sa + sb;
                e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                w   = {32'b0, a} * {32'b0, b};
                e.s = w[31:0];
                e.o = (w[63:32] != 32'd0);
            end
            4'd2: begin
                e.s = a - b;
                e.c = (a < b);
                sr  = sa - sb;
                e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd3: begin e.s = a << 1; e.c = a[31]; end
            4'd4: begin e.s = a >> 1; e.c = a[0]; end
            4'd5: begin e.s = $unsigned($signed(a) >>> 1); e.c = a[0]; end
            4'd6: e.s = a & b;
            4'd7: e.s = a | b;
            4'd8: e.s = ~a;
            4'd9: e.s = a ^ b;
            4'd10: begin
                if (b == 32'd0) begin
                    e.s = 32'hFFFF_FFFF;
                    e.o = 1'b1;
                end else begin
                    e.s = a / b;
                end
            end
            default: e.o = 1'b1;
        endcase
        e.z = (e.s == 32'd0);
        return e;
    endfunction

    function automatic int model_lat(input logic [31:0] b, input logic [3:0] op);
        return (op == 4'd1 || (op == 4'd10 && b != 32'd0)) ? 33 : 1;
    endfunction

    // Drives one transaction from a negedge; lat is the number of sampling
    // edges after the accept edge up to the first one that sees rsp_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input int stall, output int lat, output res_t got,
                          output bit stable_ok, output bit busy_ok);
        int waited;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_op = 4'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!rsp_valid && lat < 100) begin
            if (!busy || req_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
        got = {rsp_s, rsp_carry, rsp_overflow, rsp_zero};
        stable_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if ({rsp_s, rsp_carry, rsp_overflow, rsp_zero} !== got || !rsp_valid || req_ready)
                stable_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if ({rsp_s, rsp_carry, rsp_overflow, rsp_zero} !== 35'd0) begin
            bad++; $display("FAIL reset_rsp got=%h want=0", {rsp_s, rsp_carry, rsp_overflow, rsp_zero});
        end
    endtask

    task automatic test_add();
        int lat; res_t got; bit st; bit bo;
        run_op(32'hFFFF_FFFF, 32'd2, 4'd0, 0, lat, got, st, bo);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
        total++;
        if (got !== {32'd1, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL add_result got=%h want=%h", got, {32'd1, 3'b100}); end
    endtask

    task automatic test_sub();
        int lat; res_t got; bit st; bit bo;
        run_op(32'd4567, 32'd4567, 4'd2, 0, lat, got, st, bo);
        total++;
        if (got !== {32'd0, 1'b0, 1'b0, 1'b1}) begin bad++; $display("FAIL sub_equal got=%h want=%h", got, {32'd0, 3'b001}); end
        run_op(32'd5235255, 32'd5255425, 4'd2, 0, lat, got, st, bo);
        total++;
        if (got.s !== 32'd4294947126 || got.c !== 1'b1) begin
            bad++; $display("FAIL sub_borrow got s=%0d c=%b want s=4294947126 c=1", got.s, got.c);
        end
        total++;
        if (got !== model(32'd5235255, 32'd5255425, 4'd2)) begin
            bad++; $display("FAIL sub_flags got=%h want=%h", got, model(32'd5235255, 32'd5255425, 4'd2));
        end
    endtask

    task automatic test_mul();
        int lat; res_t got; bit st; bit bo;
        run_op(32'd36544, 32'd262, 4'd1, 0, lat, got, st, bo);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
        total++;
        if (got !== {32'd9574528, 3'b000}) begin bad++; $display("FAIL mul_result got=%h want=%h", got, {32'd9574528, 3'b000}); end
        total++;
        if (bo !== 1'b1) begin bad++; $display("FAIL mul_busy got=%b want=1", bo); end
    endtask

    task automatic test_div();
        int lat; res_t got; bit st; bit bo;
        run_op(32'd503, 32'd10, 4'd10, 0, lat, got, st, bo);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL div_latency got=%0d want=33", lat); end
        total++;
        if (got !== {32'd50, 3'b000}) begin bad++; $display("FAIL div_result got=%h want=%h", got, {32'd50, 3'b000}); end
        run_op(32'd0, 32'd0, 4'd10, 0, lat, got, st, bo);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL divzero_latency got=%0d want=1", lat); end
        total++;
        if (got !== {32'hFFFF_FFFF, 3'b010}) begin bad++; $display("FAIL divzero_result got=%h want=%h", got, {32'hFFFF_FFFF, 3'b010}); end
    endtask

    task automatic test_backpressure();
        logic [31:0] b0;
        res_t        got;
        bit          st;
        b0 = $urandom;
        req_a = 32'd32; req_b = b0; req_op = 4'd5; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 32'd7; req_b = 32'd9; req_op = 4'd0;
        got = {rsp_s, rsp_carry, rsp_overflow, rsp_zero};
        total++;
        if (got !== model(32'd32, b0, 4'd5) || got.s !== 32'd16) begin
            bad++; $display("FAIL bp_result got=%h want=%h", got, model(32'd32, b0, 4'd5));
        end
        st = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ({rsp_s, rsp_carry, rsp_overflow, rsp_zero} !== got || !rsp_valid || req_ready) st = 1'b0;
            @(negedge clk);
        end
        total++;
        if (st !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b want=1", st); end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if ({busy, req_ready, rsp_valid} !== 3'b010) begin
            bad++; $display("FAIL bp_no_accept_on_handshake got=%b want=010", {busy, req_ready, rsp_valid});
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (!rsp_valid || {rsp_s, rsp_carry, rsp_overflow, rsp_zero} !== model(32'd7, 32'd9, 4'd0)) begin
            bad++; $display("FAIL bp_second got=%h valid=%b want=%h", {rsp_s, rsp_carry, rsp_overflow, rsp_zero}, rsp_valid, model(32'd7, 32'd9, 4'd0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int  lat; res_t got; bit st; bit bo; bit seen;
        req_a = 32'd743896; req_b = 32'd3333583; req_op = 4'd1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, req_ready, rsp_valid, rsp_s, rsp_carry, rsp_overflow, rsp_zero} !== {3'b010, 35'd0}) begin
            bad++; $display("FAIL midreset_outputs busy=%b ready=%b valid=%b rsp=%h want 0/1/0/0", busy, req_ready, rsp_valid, {rsp_s, rsp_carry, rsp_overflow, rsp_zero});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_response got=%b want=0", seen); end
        run_op(32'd0, $urandom, 4'd8, 0, lat, got, st, bo);
        total++;
        if (lat !== 1 || got !== {32'hFFFF_FFFF, 3'b000}) begin
            bad++; $display("FAIL midreset_next got=%h lat=%0d want=%h lat=1", got, lat, {32'hFFFF_FFFF, 3'b000});
        end
    endtask

    task automatic test_random();
        int          lat; res_t got; bit st; bit bo; int stall;
        logic [31:0] a; logic [31:0] b; logic [3:0] op;
        for (int n = 0; n < 60; n++) begin
            a  = $urandom;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
            stall = $urandom_range(0, 2);
            run_op(a, b, op, stall, lat, got, st, bo);
            total++;
            if (got !== model(a, b, op)) begin
                bad++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h want=%h", op, a, b, got, model(a, b, op));
            end
            total++;
            if (lat !== model_lat(b, op)) begin
                bad++; $display("FAIL rand_latency op=%0d b=%h got=%0d want=%0d", op, b, lat, model_lat(b, op));
            end
            total++;
            if (st !== 1'b1 || bo !== 1'b1) begin
                bad++; $display("FAIL rand_hold op=%0d stable=%b busy=%b want 1/1", op, st, bo);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
